sumador_pipe: RTL and testbench

//  Parametrised, 2-stage pipelined successor to the combinational 3-operand adder (sumador).

---
 rtl/sumador_pkg.sv | 22 ++
 rtl/sumador_sat.sv | 23 ++
 rtl/sumador_pipe.sv | 125 ++++++++++++
 tb/tb_sumador_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sumador_pkg.sv
// Shared operation codes and the wrap/clamp helper used by the datapath adders.
package sumador_pkg;

   localparam logic [1:0] OP_ADD  = 2'd0;
   localparam logic [1:0] OP_SUB  = 2'd1;
   localparam logic [1:0] OP_ADD3 = 2'd2;
   localparam logic [1:0] OP_ACC  = 2'd3;

   // Clamp a signed value into [0, 2^width-1]; width must stay below 63.
   function automatic logic [63:0] clamp_w(input logic signed [63:0] full,
                                           input int unsigned       width);
      logic signed [63:0] w_max;
      w_max = (64'sd1 <<< width) - 64'sd1;
      if (full < 64'sd0)
         clamp_w = '0;
      else if (full > w_max)
         clamp_w = w_max;
      else
         clamp_w = full;
   endfunction

endpackage

// File: rtl/sumador_sat.sv
// Folds a signed stage-2 sum into WIDTH bits (wrap or clamp) and flags out-of-range.
module sumador_sat
   import sumador_pkg::*;
#(
   parameter int unsigned WIDTH = 14,
   parameter bit          SAT   = 1'b0
) (
   input  logic [WIDTH+2:0] i_full,
   output logic [WIDTH-1:0] o_res_c,
   output logic             o_ovf_c
);

   logic [63:0] w_clamp;
   logic        w_unused_clamp;

   assign w_clamp        = clamp_w(64'($signed(i_full)), WIDTH);
   assign w_unused_clamp = ^w_clamp[63:WIDTH];

   // Negative (sign bit) or >= 2^WIDTH (any bit at or above WIDTH) is out of range.
   assign o_ovf_c = |i_full[WIDTH+2:WIDTH];
   assign o_res_c = SAT ? w_clamp[WIDTH-1:0] : i_full[WIDTH-1:0];

endmodule

// File: rtl/sumador_pipe.sv
// Two-stage pipelined add/sub/3-operand/accumulate unit with valid/ready on both sides.
module sumador_pipe
   import sumador_pkg::*;
#(
   parameter int unsigned WIDTH = 14,
   parameter bit          SAT   = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [1:0]       oper,
   input  logic             clr_acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             ovf,
   output logic [WIDTH-1:0] acc
);

   localparam int unsigned PW = WIDTH + 2;
   // One bit wider than the stage-1 value so a+b+c and acc+p never wrap internally.
   localparam int unsigned FW = WIDTH + 3;

   logic             r_s1_valid;
   logic [PW-1:0]    r_s1_p;
   logic [WIDTH-1:0] r_s1_c;
   logic [1:0]       r_s1_oper;
   logic             r_s2_valid;
   logic [WIDTH-1:0] r_res;
   logic             r_ovf;
   logic [WIDTH-1:0] r_acc;

   logic             w_s2_adv;
   logic             w_s1_adv;
   logic             w_s2_load;
   logic [PW-1:0]    w_p;
   logic [FW-1:0]    w_p_ext;
   logic [FW-1:0]    w_full;
   logic [WIDTH-1:0] w_acc_base;
   logic [WIDTH-1:0] w_sat_res;
   logic             w_sat_ovf;

   assign w_s2_adv  = !r_s2_valid | out_ready;
   assign w_s1_adv  = !r_s1_valid | w_s2_adv;
   assign w_s2_load = w_s2_adv & r_s1_valid;
   assign in_ready  = w_s1_adv;

   // Stage-1 operation: two's complement result held in PW bits.
   always_comb begin
      w_p = {2'b00, a} + {2'b00, b};
      if (oper == OP_SUB)
         w_p = {2'b00, a} - {2'b00, b};
   end

   // Clear takes priority over the value an entering accumulate item would read.
   assign w_acc_base = clr_acc ? '0 : r_acc;
   assign w_p_ext    = {r_s1_p[PW-1], r_s1_p};

   always_comb begin
      w_full = w_p_ext;
      case (r_s1_oper)
         OP_ADD3: w_full = w_p_ext + {3'b000, r_s1_c};
         OP_ACC:  w_full = w_p_ext + {3'b000, w_acc_base};
         default: w_full = w_p_ext;
      endcase
   end

   sumador_sat #(
      .WIDTH (WIDTH),
      .SAT   (SAT)
   ) u_sat (
      .i_full  (w_full),
      .o_res_c (w_sat_res),
      .o_ovf_c (w_sat_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_p     <= '0;
         r_s1_c     <= '0;
         r_s1_oper  <= OP_ADD;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_p    <= w_p;
            r_s1_c    <= c;
            r_s1_oper <= oper;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_res      <= '0;
         r_ovf      <= 1'b0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_res <= w_sat_res;
            r_ovf <= w_sat_ovf;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_acc <= '0;
      else if (w_s2_load && (r_s1_oper == OP_ACC))
         r_acc <= w_sat_res;
      else if (clr_acc)
         r_acc <= '0;
   end

   assign out_valid = r_s2_valid;
   assign res       = r_res;
   assign ovf       = r_ovf;
   assign acc       = r_acc;

endmodule

// File: tb/tb_sumador_pipe.sv
// Bench for sumador_pipe: three instances (14/wrap, 14/clamp, 8/clamp) share one stimulus stream.
module tb_sumador_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, clr_acc, out_ready;
   logic [13:0] a, b, c;
   logic [1:0]  oper;

   logic        ir0, ir1, ir2, ov0, ov1, ov2, of0, of1, of2;
   logic [13:0] res0, res1, acc0, acc1;
   logic [7:0]  res2, acc2;

   logic        ir [3];
   logic        ov [3];
   logic        of [3];
   logic [13:0] rs [3];
   logic [13:0] ac [3];

   always #5 clk = ~clk;

   sumador_pipe #(.WIDTH(14), .SAT(1'b0)) u_w14 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b), .c(c),
      .oper(oper), .clr_acc(clr_acc), .out_valid(ov0), .out_ready(out_ready),
      .res(res0), .ovf(of0), .acc(acc0));

   sumador_pipe #(.WIDTH(14), .SAT(1'b1)) u_s14 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b), .c(c),
      .oper(oper), .clr_acc(clr_acc), .out_valid(ov1), .out_ready(out_ready),
      .res(res1), .ovf(of1), .acc(acc1));

   sumador_pipe #(.WIDTH(8), .SAT(1'b1)) u_s8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .a(a[7:0]), .b(b[7:0]),
      .c(c[7:0]), .oper(oper), .clr_acc(clr_acc), .out_valid(ov2), .out_ready(out_ready),
      .res(res2), .ovf(of2), .acc(acc2));

   assign ir[0] = ir0;  assign ir[1] = ir1;  assign ir[2] = ir2;
   assign ov[0] = ov0;  assign ov[1] = ov1;  assign ov[2] = ov2;
   assign of[0] = of0;  assign of[1] = of1;  assign of[2] = of2;
   assign rs[0] = res0; assign rs[1] = res1; assign rs[2] = {6'b0, res2};
   assign ac[0] = acc0; assign ac[1] = acc1; assign ac[2] = {6'b0, acc2};

   typedef struct {
      logic [2:0][13:0] res;
      logic [2:0]       ovf;
      logic [2:0][13:0] acc;
   } exp_t;

   typedef struct {
      int a, b, c, op;
      int r0, o0, r1, o1;
   } vec_t;

   int    checks = 0;
   int    errors = 0;
   int    npop   = 0;
   int    macc [3];
   exp_t  sb [$];
   exp_t  e_tab;
   logic  use_model;
   vec_t  tab [10];

   function automatic int wid(input int k);
      return (k == 2) ? 8 : 14;
   endfunction

   function automatic bit sat(input int k);
      return k != 0;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   // Reference: exact integer arithmetic, then wrap or clamp into the instance width.
   task automatic model(input int k, input int av, input int bv, input int cv, input int op,
                        output logic [13:0] r, output logic o);
      longint mx, full, rv, x, y, z;
      mx = (longint'(1) << wid(k)) - 1;
      x = longint'(av) & mx; y = longint'(bv) & mx; z = longint'(cv) & mx;
      case (op)
         0:       full = x + y;
         1:       full = x - y;
         2:       full = x + y + z;
         default: full = longint'(macc[k]) + x + y;
      endcase
      o = (full < 0) || (full > mx);
      if (sat(k)) rv = (full < 0) ? 0 : ((full > mx) ? mx : full);
      else        rv = full & mx;
      r = 14'(rv);
      if (op == 3) macc[k] = int'(rv);
   endtask

   // One clock: drive after the falling edge, then score the output and input transfers.
   task automatic cycle(input logic iv, input int av, input int bv, input int cv, input int op,
                        input logic clr, input logic ordy, output logic accd);
      exp_t e;
      logic [13:0] r;
      logic o;
      @(negedge clk);
      in_valid = iv; a = 14'(av); b = 14'(bv); c = 14'(cv); oper = 2'(op);
      clr_acc = clr; out_ready = ordy;
      #1;
      if (ov[0] && ordy) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out got res=%0d expected no output", rs[0]);
         end else begin
            e = sb.pop_front();
            npop++;
            for (int k = 0; k < 3; k++) begin
               chk($sformatf("out_valid%0d", k), 64'(ov[k]), 64'd1);
               chk($sformatf("res%0d", k), 64'(rs[k]), 64'(e.res[k]));
               chk($sformatf("ovf%0d", k), 64'(of[k]), 64'(e.ovf[k]));
               chk($sformatf("acc%0d", k), 64'(ac[k]), 64'(e.acc[k]));
            end
         end
      end
      accd = iv && ir[0];
      if (accd) begin
         for (int k = 0; k < 3; k++) begin
            if (use_model || k == 2) begin
               model(k, av, bv, cv, op, r, o);
               e.res[k] = r; e.ovf[k] = o;
            end else begin
               e.res[k] = e_tab.res[k]; e.ovf[k] = e_tab.ovf[k];
            end
            e.acc[k] = 14'(macc[k]);
         end
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      logic accd;
      for (int i = 0; i < 12 && sb.size() > 0; i++)
         cycle(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, accd);
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      logic        accd, seen_block;
      logic [13:0] held;
      int          sent, p0, av, bv, cv;

      tab[0] = '{1, 3, 3, 2,          7, 0,     7, 0};
      tab[1] = '{121, 12, 100, 2,     233, 0,   233, 0};
      tab[2] = '{16383, 1, 0, 0,      0, 1,     16383, 1};
      tab[3] = '{2, 3, 0, 1,          16383, 1, 0, 1};
      tab[4] = '{100, 200, 0, 0,      300, 0,   300, 0};
      tab[5] = '{500, 20, 0, 1,       480, 0,   480, 0};
      tab[6] = '{16383, 16383, 16383, 2, 16381, 1, 16383, 1};
      tab[7] = '{0, 16383, 0, 1,      1, 1,     0, 1};
      tab[8] = '{8191, 8192, 0, 0,    16383, 0, 16383, 0};
      tab[9] = '{7, 7, 0, 1,          0, 0,     0, 0};

      macc = '{0, 0, 0};
      use_model = 1'b1;
      rst_n = 1'b0; in_valid = 1'b0; clr_acc = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; c = '0; oper = 2'd0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 64'(ov[0]), 0);
      chk("rst_res", 64'(rs[0]), 0);
      chk("rst_ovf", 64'(of[0]), 0);
      chk("rst_acc", 64'(ac[0]), 0);
      rst_n = 1'b1;
      #1 chk("rst_in_ready", 64'(ir[0]), 1);

      // Directed vectors, back to back
      use_model = 1'b0;
      for (int i = 0; i < 10; i++) begin
         e_tab.res[0] = 14'(tab[i].r0); e_tab.ovf[0] = tab[i].o0[0];
         e_tab.res[1] = 14'(tab[i].r1); e_tab.ovf[1] = tab[i].o1[0];
         cycle(1'b1, tab[i].a, tab[i].b, tab[i].c, tab[i].op, 1'b0, 1'b1, accd);
         chk("tab_accept", 64'(accd), 1);
      end
      drain();
      use_model = 1'b1;

      // Latency from an idle pipeline
      cycle(1'b1, 1, 3, 3, 2, 1'b0, 1'b1, accd);
      cycle(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, accd);
      chk("lat_cycle1_valid", 64'(ov[0]), 0);
      cycle(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, accd);
      chk("lat_cycle2_valid", 64'(ov[0]), 1);
      drain();

      // Accumulator chain, then clear coincident with an accumulate entering stage 2
      cycle(1'b0, 0, 0, 0, 0, 1'b1, 1'b1, accd);
      macc = '{0, 0, 0};
      cycle(1'b1, 1, 2, 0, 3, 1'b0, 1'b1, accd);
      cycle(1'b1, 3, 4, 0, 3, 1'b0, 1'b1, accd);
      cycle(1'b1, 5, 0, 0, 3, 1'b0, 1'b1, accd);
      drain();
      chk("acc_chain", 64'(ac[0]), 15);
      chk("acc_chain_sat", 64'(ac[1]), 15);
      macc = '{0, 0, 0};
      cycle(1'b1, 2, 2, 0, 3, 1'b0, 1'b1, accd);
      cycle(1'b0, 0, 0, 0, 0, 1'b1, 1'b1, accd);
      drain();
      chk("acc_clr_coincident", 64'(ac[0]), 4);

      // Streaming with a four-cycle output stall
      sent = 0; seen_block = 1'b0; held = '0; p0 = npop;
      for (int k = 0; k < 40 && (sent < 8 || sb.size() > 0); k++) begin
         cycle(sent < 8, sent, sent, 0, 0, 1'b0, !(k >= 3 && k <= 6), accd);
         if (accd) sent++;
         if (!ir[0]) seen_block = 1'b1;
         if (k == 3) held = rs[0];
         if (k >= 4 && k <= 6) begin
            chk("stall_res_hold", 64'(rs[0]), 64'(held));
            chk("stall_valid_hold", 64'(ov[0]), 1);
         end
      end
      chk("stall_in_ready_low", 64'(seen_block), 1);
      chk("stream_count", 64'(npop - p0), 8);

      // Asynchronous reset with both stages occupied
      cycle(1'b1, 10, 20, 0, 0, 1'b0, 1'b1, accd);
      cycle(1'b1, 30, 40, 0, 0, 1'b0, 1'b0, accd);
      cycle(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, accd);
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(ov[0]), 0);
      chk("arst_res", 64'(rs[0]), 0);
      chk("arst_acc", 64'(ac[0]), 0);
      sb.delete();
      macc = '{0, 0, 0};
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, accd);
      chk("post_rst_no_output", 64'(ov[0]), 0);
      cycle(1'b1, 9, 4, 0, 1, 1'b0, 1'b1, accd);
      cycle(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, accd);
      chk("post_rst_lat1", 64'(ov[0]), 0);
      cycle(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, accd);
      chk("post_rst_lat2", 64'(ov[0]), 1);
      drain();

      // Random handshakes against the reference model
      sent = 0;
      for (int k = 0; k < 60000 && sent < 10000; k++) begin
         av = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 16383 : 0)
                                          : int'($urandom_range(0, 16383));
         bv = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 16383 : 255)
                                          : int'($urandom_range(0, 16383));
         cv = int'($urandom_range(0, 16383));
         cycle($urandom_range(0, 9) < 7, av, bv, cv, int'($urandom_range(0, 3)), 1'b0,
               $urandom_range(0, 9) < 7, accd);
         if (accd) begin
            sent++;
            if (sent % 1000 == 0) begin
               drain();
               cycle(1'b0, 0, 0, 0, 0, 1'b1, 1'b1, accd);
               macc = '{0, 0, 0};
            end
         end
      end
      chk("random_items_sent", 64'(sent), 10000);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
